// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer in front of the single-request-port 32-bit SRAM controller.
// Optional build macro SRAM_ARB_RR_EN selects round-robin tie-breaking; default is fixed priority (port 0 first).
module sram_port_arbiter #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rden0,
  input  logic              i_wren0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [31:0]       i_wdata0,
  input  logic [3:0]        i_bmask0,
  output logic [31:0]       o_rdata0,
  output logic              o_ack0,
  input  logic              i_rden1,
  input  logic              i_wren1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [31:0]       i_wdata1,
  input  logic [3:0]        i_bmask1,
  output logic [31:0]       o_rdata1,
  output logic              o_ack1,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [31:0]       o_m_wdata,
  output logic [3:0]        o_m_bmask,
  output logic              o_m_rden,
  output logic              o_m_wren,
  input  logic [31:0]       i_m_rdata,
  input  logic              i_m_ack,
  output logic              o_busy,
  output logic              o_owner,
  output logic              o_timeout
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit          TO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   bmask_q, bmask_d;
  logic                wr_q, wr_d;
  logic                owner_q, owner_d;
  logic                m_rden_q, m_rden_d;
  logic                m_wren_q, m_wren_d;
  logic                busy_q, busy_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                req0;
  logic                req1;
  logic                gnt;
  logic                end_txn;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [MASK_W-1:0]   sel_bmask;
  logic                sel_wr;

  assign req0 = i_rden0 | i_wren0;
  assign req1 = i_rden1 | i_wren1;

  // Winner selection; only consulted in IDLE when at least one port requests.
  always_comb begin
`ifdef SRAM_ARB_RR_EN
    if (req0 && req1) begin
      gnt = ~owner_q;
    end else begin
      gnt = req1;
    end
`else
    gnt = ~req0;
`endif
  end

  // Payload of the winning port; a simultaneous rden+wren counts as a write.
  always_comb begin
    sel_addr  = gnt ? i_addr1  : i_addr0;
    sel_wdata = gnt ? i_wdata1 : i_wdata0;
    sel_bmask = gnt ? i_bmask1 : i_bmask0;
    sel_wr    = gnt ? i_wren1  : i_wren0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bmask_d   = bmask_q;
    wr_d      = wr_q;
    owner_d   = owner_q;
    m_rden_d  = m_rden_q;
    m_wren_d  = m_wren_q;
    busy_d    = busy_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    end_txn   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          bmask_d  = sel_bmask;
          wr_d     = sel_wr;
          owner_d  = gnt;
          m_rden_d = ~sel_wr;
          m_wren_d = sel_wr;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_m_ack) begin
          if (!wr_q) begin
            if (owner_q) begin
              rdata1_d = i_m_rdata;
            end else begin
              rdata0_d = i_m_rdata;
            end
          end
          end_txn = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          // Watchdog abort: owner gets zero data and a normal completion pulse.
          timeout_d = 1'b1;
          if (owner_q) begin
            rdata1_d = '0;
          end else begin
            rdata0_d = '0;
          end
          end_txn = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (end_txn) begin
      state_d  = ST_DONE;
      m_rden_d = 1'b0;
      m_wren_d = 1'b0;
      busy_d   = 1'b0;
      ack0_d   = ~owner_q;
      ack1_d   = owner_q;
    end
  end

  // State register; reset drops any in-flight transaction immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      bmask_q   <= '0;
      wr_q      <= 1'b0;
      owner_q   <= 1'b0;
      m_rden_q  <= 1'b0;
      m_wren_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bmask_q   <= bmask_d;
      wr_q      <= wr_d;
      owner_q   <= owner_d;
      m_rden_q  <= m_rden_d;
      m_wren_q  <= m_wren_d;
      busy_q    <= busy_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_m_addr  = addr_q;
  assign o_m_wdata = wdata_q;
  assign o_m_bmask = bmask_q;
  assign o_m_rden  = m_rden_q;
  assign o_m_wren  = m_wren_q;
  assign o_busy    = busy_q;
  assign o_owner   = owner_q;
  assign o_timeout = timeout_q;
  assign o_ack0    = ack0_q;
  assign o_ack1    = ack1_q;
  assign o_rdata0  = rdata0_q;
  assign o_rdata1  = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (bench plays both requesters and the SRAM controller).
module tb_sram_port_arbiter;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned TO_CYC = 8;
  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_DONE = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rden0, wren0, rden1, wren1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic [3:0]        bmask0, bmask1;
  logic [31:0]       rdata0, rdata1;
  logic              ack0, ack1;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, m_rdata;
  logic [3:0]        m_bmask;
  logic              m_rden, m_wren, m_ack;
  logic              busy, owner, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0]       exp_rd [2];
  logic              model_owner;
  logic              model_to;

  // Random-traffic requester state
  logic [1:0]        r_pend, r_wr, r_both;
  logic [ADDR_W-1:0] r_addr [2];
  logic [31:0]       r_wd [2];
  logic [3:0]        r_bm [2];

  sram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rden0(rden0), .i_wren0(wren0), .i_addr0(addr0), .i_wdata0(wdata0), .i_bmask0(bmask0),
    .o_rdata0(rdata0), .o_ack0(ack0),
    .i_rden1(rden1), .i_wren1(wren1), .i_addr1(addr1), .i_wdata1(wdata1), .i_bmask1(bmask1),
    .o_rdata1(rdata1), .o_ack1(ack1),
    .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_bmask(m_bmask),
    .o_m_rden(m_rden), .o_m_wren(m_wren), .i_m_rdata(m_rdata), .i_m_ack(m_ack),
    .o_busy(busy), .o_owner(owner), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    rden0 = 0; wren0 = 0; rden1 = 0; wren1 = 0; m_ack = 0;
  endtask

  // Arbitration rule: a lone requester wins; ties go to port 0, or to the port not granted last with RR.
  function automatic logic model_winner(input logic r0, input logic r1, input logic last);
    if (r0 != r1) return r1;
`ifdef SRAM_ARB_RR_EN
    return ~last;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; bmask0 = '0; bmask1 = '0; m_rdata = '0;
    repeat (3) tick();
    n_checks++;
    if ({m_rden, m_wren, busy, owner, timeout, ack0, ack1} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000", {m_rden, m_wren, busy, owner, timeout, ack0, ack1});
    end
    n_checks++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0 || m_addr !== '0 || m_wdata !== 32'h0 || m_bmask !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata0=%h rdata1=%h m_addr=%h m_wdata=%h m_bmask=%h want all 0",
               rdata0, rdata1, m_addr, m_wdata, m_bmask);
    end
    rst_n = 1;
    tick();
    model_owner = 0; model_to = 0; exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic test_read_p0();
    rden0 = 1; addr0 = 18'h00100; wdata0 = $urandom; bmask0 = 4'hF;
    tick();
    n_checks++;
    if (m_rden !== 1 || m_wren !== 0 || m_addr !== 18'h00100 || busy !== 1 || owner !== 0) begin
      n_fail++;
      $display("FAIL rd0_issue: rden=%b wren=%b addr=%h busy=%b owner=%b want 1 0 00100 1 0",
               m_rden, m_wren, m_addr, busy, owner);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (m_rden !== 1 || ack0 !== 0 || ack1 !== 0) begin
        n_fail++;
        $display("FAIL rd0_hold%0d: rden=%b ack0=%b ack1=%b want 1 0 0", i, m_rden, ack0, ack1);
      end
    end
    m_ack = 1; m_rdata = 32'h12345678;
    tick();
    n_checks++;
    if (ack0 !== 1 || ack1 !== 0 || m_rden !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL rd0_done: ack0=%b ack1=%b rden=%b busy=%b want 1 0 0 0", ack0, ack1, m_rden, busy);
    end
    n_checks++;
    if (rdata0 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rd0_data: got %h want 12345678", rdata0);
    end
    exp_rd[0] = 32'h12345678;
    rden0 = 0; m_ack = 0;
    tick();
    n_checks++;
    if (ack0 !== 0 || ack1 !== 0 || rdata0 !== exp_rd[0]) begin
      n_fail++;
      $display("FAIL rd0_after: ack0=%b ack1=%b rdata0=%h want 0 0 %h", ack0, ack1, rdata0, exp_rd[0]);
    end
    model_owner = 0;
  endtask

  task automatic test_write_p1();
    rden1 = 1; wren1 = 1; addr1 = 18'h3FFFC; wdata1 = 32'hA5A5A5A5; bmask1 = 4'b0011;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m_wren !== 1 || m_rden !== 0 || m_addr !== 18'h3FFFC || m_wdata !== 32'hA5A5A5A5 ||
          m_bmask !== 4'b0011 || owner !== 1 || busy !== 1) begin
        n_fail++;
        $display("FAIL wr1_busy%0d: wren=%b rden=%b addr=%h wdata=%h bmask=%b owner=%b busy=%b want 1 0 3fffc a5a5a5a5 0011 1 1",
                 i, m_wren, m_rden, m_addr, m_wdata, m_bmask, owner, busy);
      end
      if (i == 3) begin m_ack = 1; m_rdata = 32'hDEADBEEF; end
      tick();
    end
    n_checks++;
    if (ack1 !== 1 || ack0 !== 0 || m_wren !== 0 || rdata1 !== exp_rd[1]) begin
      n_fail++;
      $display("FAIL wr1_done: ack1=%b ack0=%b wren=%b rdata1=%h want 1 0 0 %h", ack1, ack0, m_wren, rdata1, exp_rd[1]);
    end
    rden1 = 0; wren1 = 0; m_ack = 0;
    tick();
    n_checks++;
    if (ack1 !== 0 || rdata1 !== exp_rd[1] || rdata0 !== exp_rd[0]) begin
      n_fail++;
      $display("FAIL wr1_after: ack1=%b rdata1=%h rdata0=%h want 0 %h %h", ack1, rdata1, rdata0, exp_rd[1], exp_rd[0]);
    end
    model_owner = 1;
  endtask

  task automatic test_arbitration();
    logic        w;
    logic [31:0] rd;
    rden0 = 1; addr0 = 18'h01234; rden1 = 1; addr1 = 18'h2ABCD;
    for (int k = 0; k < 6; k++) begin
      tick();
      w = model_winner(1'b1, 1'b1, model_owner);
      model_owner = w;
      n_checks++;
      if (m_rden !== 1 || owner !== w || m_addr !== (w ? 18'h2ABCD : 18'h01234)) begin
        n_fail++;
        $display("FAIL arb_grant%0d: rden=%b owner=%b addr=%h want 1 %b %h", k, m_rden, owner, m_addr, w,
                 w ? 18'h2ABCD : 18'h01234);
      end
      rd = $urandom; m_ack = 1; m_rdata = rd;
      tick();
      exp_rd[w] = rd;
      n_checks++;
      if (ack0 !== !w || ack1 !== w || rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
        n_fail++;
        $display("FAIL arb_ack%0d: ack0=%b ack1=%b rdata0=%h rdata1=%h want %b %b %h %h",
                 k, ack0, ack1, rdata0, rdata1, !w, w, exp_rd[0], exp_rd[1]);
      end
      m_ack = 0;
      tick();
    end
    rden0 = 0; rden1 = 0;
  endtask

  task automatic test_timeout();
    int nbusy = 0;
    int guard = 0;
    rden0 = 1; addr0 = 18'h0ABCD;
    tick();
    while (ack0 !== 1 && guard < 40) begin
      if (busy === 1) nbusy++;
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 40 || nbusy != TO_CYC) begin
      n_fail++;
      $display("FAIL to_busy_cycles: got %0d busy cycles (guard %0d) want %0d", nbusy, guard, TO_CYC);
    end
    n_checks++;
    if (ack0 !== 1 || rdata0 !== 32'h0 || timeout !== 1 || m_rden !== 0) begin
      n_fail++;
      $display("FAIL to_done: ack0=%b rdata0=%h timeout=%b rden=%b want 1 0 1 0", ack0, rdata0, timeout, m_rden);
    end
    exp_rd[0] = '0; model_to = 1; model_owner = 0;
    rden0 = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] q [4];
    logic [31:0]       rd;
    int                t0;
    for (int k = 0; k < 4; k++) q[k] = ADDR_W'($urandom);
    rden0 = 1; addr0 = q[0]; t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (m_rden !== 1 || m_addr !== q[k] || owner !== 0) begin
        n_fail++;
        $display("FAIL b2b_issue%0d: rden=%b addr=%h owner=%b want 1 %h 0", k, m_rden, m_addr, owner, q[k]);
      end
      tick();
      rd = $urandom; m_ack = 1; m_rdata = rd;
      tick();
      n_checks++;
      if (ack0 !== 1 || rdata0 !== rd || (cyc - t0) != 3 || timeout !== model_to) begin
        n_fail++;
        $display("FAIL b2b_done%0d: ack0=%b rdata0=%h latency=%0d timeout=%b want 1 %h 3 %b",
                 k, ack0, rdata0, cyc - t0, timeout, rd, model_to);
      end
      exp_rd[0] = rd;
      m_ack = 0; rden0 = 0;
      tick();
      if (k < 3) begin rden0 = 1; addr0 = q[k+1]; t0 = cyc; end
    end
    model_owner = 0;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd;
    rden0 = 1; addr0 = 18'h00444;
    tick();
    tick();
    n_checks++;
    if (busy !== 1 || m_rden !== 1) begin
      n_fail++;
      $display("FAIL rst_pre: busy=%b rden=%b want 1 1", busy, m_rden);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (m_rden !== 0 || busy !== 0 || ack0 !== 0 || ack1 !== 0 || timeout !== 0 || rdata0 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: rden=%b busy=%b ack0=%b ack1=%b timeout=%b rdata0=%h want all 0",
               m_rden, busy, ack0, ack1, timeout, rdata0);
    end
    rden0 = 0;
    tick();
    rst_n = 1;
    model_owner = 0; model_to = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    tick();
    m_ack = 1; m_rdata = 32'hBAD0BAD0;
    tick();
    n_checks++;
    if (ack0 !== 0 || ack1 !== 0 || busy !== 0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL stale_ack: ack0=%b ack1=%b busy=%b rdata0=%h rdata1=%h want 0 0 0 0 0",
               ack0, ack1, busy, rdata0, rdata1);
    end
    m_ack = 0;
    rden1 = 1; addr1 = 18'h1F00C;
    tick();
    n_checks++;
    if (m_rden !== 1 || owner !== 1 || m_addr !== 18'h1F00C) begin
      n_fail++;
      $display("FAIL rst_p1_issue: rden=%b owner=%b addr=%h want 1 1 1f00c", m_rden, owner, m_addr);
    end
    rd = $urandom; m_ack = 1; m_rdata = rd;
    tick();
    n_checks++;
    if (ack1 !== 1 || ack0 !== 0 || rdata1 !== rd) begin
      n_fail++;
      $display("FAIL rst_p1_done: ack1=%b ack0=%b rdata1=%h want 1 0 %h", ack1, ack0, rdata1, rd);
    end
    exp_rd[1] = rd; model_owner = 1;
    m_ack = 0; rden1 = 0;
    tick();
  endtask

  task automatic drive_ports();
    rden0 = r_pend[0] & (~r_wr[0] | r_both[0]);
    wren0 = r_pend[0] & r_wr[0];
    addr0 = r_addr[0]; wdata0 = r_wd[0]; bmask0 = r_bm[0];
    rden1 = r_pend[1] & (~r_wr[1] | r_both[1]);
    wren1 = r_pend[1] & r_wr[1];
    addr1 = r_addr[1]; wdata1 = r_wd[1]; bmask1 = r_bm[1];
  endtask

  task automatic test_random();
    int          ph;
    int          nxt;
    int          left;
    logic [1:0]  snap;
    logic        cur;
    logic        acked;
    logic [31:0] rd;
    int          ntxn;
    ph = PH_IDLE; snap = 2'b00; cur = 0; left = 0; rd = '0; ntxn = 0;
    r_pend = '0; r_wr = '0; r_both = '0;
    for (int p = 0; p < 2; p++) begin r_addr[p] = '0; r_wd[p] = '0; r_bm[p] = '0; end
    drive_ports();
    for (int c = 0; c < 3000; c++) begin
      acked = m_ack;
      tick();
      nxt = ph;
      case (ph)
        PH_IDLE: begin
          if (snap != 2'b00) begin
            cur = model_winner(snap[0], snap[1], model_owner);
            model_owner = cur;
            n_checks++;
            if (busy !== 1 || owner !== cur || m_addr !== r_addr[cur] || m_wren !== r_wr[cur] ||
                m_rden !== !r_wr[cur] || ack0 !== 0 || ack1 !== 0) begin
              n_fail++;
              $display("FAIL rnd_grant c%0d: busy=%b owner=%b addr=%h wren=%b rden=%b want 1 %b %h %b %b",
                       c, busy, owner, m_addr, m_wren, m_rden, cur, r_addr[cur], r_wr[cur], !r_wr[cur]);
            end
            if (r_wr[cur]) begin
              n_checks++;
              if (m_wdata !== r_wd[cur] || m_bmask !== r_bm[cur]) begin
                n_fail++;
                $display("FAIL rnd_wpay c%0d: wdata=%h bmask=%b want %h %b", c, m_wdata, m_bmask, r_wd[cur], r_bm[cur]);
              end
            end
            left = $urandom_range(0, 4);
            nxt = PH_BUSY;
          end else begin
            n_checks++;
            if (busy !== 0 || m_rden !== 0 || m_wren !== 0 || ack0 !== 0 || ack1 !== 0) begin
              n_fail++;
              $display("FAIL rnd_idle c%0d: busy=%b rden=%b wren=%b ack0=%b ack1=%b want 0", c, busy, m_rden, m_wren, ack0, ack1);
            end
          end
        end
        PH_BUSY: begin
          if (acked) begin
            if (!r_wr[cur]) exp_rd[cur] = rd;
            n_checks++;
            if (ack0 !== !cur || ack1 !== cur || busy !== 0 || m_rden !== 0 || m_wren !== 0 ||
                rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
              n_fail++;
              $display("FAIL rnd_done c%0d: ack0=%b ack1=%b busy=%b rdata0=%h rdata1=%h want %b %b 0 %h %h",
                       c, ack0, ack1, busy, rdata0, rdata1, !cur, cur, exp_rd[0], exp_rd[1]);
            end
            r_pend[cur] = 1'b0;
            ntxn++;
            nxt = PH_DONE;
          end else begin
            n_checks++;
            if (busy !== 1 || owner !== cur || m_addr !== r_addr[cur] || (m_rden | m_wren) !== 1 ||
                ack0 !== 0 || ack1 !== 0) begin
              n_fail++;
              $display("FAIL rnd_busy c%0d: busy=%b owner=%b addr=%h req=%b want 1 %b %h 1",
                       c, busy, owner, m_addr, m_rden | m_wren, cur, r_addr[cur]);
            end
          end
        end
        default: begin
          n_checks++;
          if (busy !== 0 || m_rden !== 0 || m_wren !== 0 || ack0 !== 0 || ack1 !== 0) begin
            n_fail++;
            $display("FAIL rnd_post c%0d: busy=%b rden=%b wren=%b ack0=%b ack1=%b want 0", c, busy, m_rden, m_wren, ack0, ack1);
          end
          nxt = PH_IDLE;
        end
      endcase
      ph = nxt;
      m_rdata = $urandom;
      if (ph == PH_BUSY) begin
        m_ack = (left == 0);
        if (left == 0) rd = m_rdata;
        else left--;
      end else begin
        m_ack = ($urandom_range(0, 7) == 0);
      end
      if (c < 1200) begin
        for (int p = 0; p < 2; p++) begin
          if (!r_pend[p] && $urandom_range(0, 2) == 0) begin
            r_pend[p] = 1'b1;
            r_wr[p]   = 1'($urandom_range(0, 1));
            r_both[p] = 1'($urandom_range(0, 1));
            r_addr[p] = ADDR_W'($urandom);
            r_wd[p]   = $urandom;
            r_bm[p]   = 4'($urandom);
          end
        end
      end
      drive_ports();
      snap = r_pend;
      if (c >= 1200 && r_pend == 2'b00 && ph == PH_IDLE) break;
    end
    m_ack = 0;
    n_checks++;
    if (r_pend != 2'b00 || ph != PH_IDLE || ntxn < 50 || timeout !== model_to) begin
      n_fail++;
      $display("FAIL rnd_drain: pend=%b phase=%0d txns=%0d timeout=%b want 00 0 >=50 %b", r_pend, ph, ntxn, timeout, model_to);
    end
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_read_p0();
    test_write_p1();
    test_arbitration();
    test_timeout();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
